// File: rtl/signed_or_unsigned_div.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned per operation.
// Valid/ready operand port in, valid/ready result port out; results follow SV / and % semantics.
module signed_or_unsigned_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  dvd_q, dvd_d;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [n-1:0]  dvs_q, dvs_d;   // divisor magnitude
  logic [n-1:0]  part_q, part_d; // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quot_q, neg_quot_d;
  logic          neg_rem_q, neg_rem_d;
  logic [n-1:0]  quot_q, quot_d;
  logic [n-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [n:0]    shifted;
  logic [n:0]    trial;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    part_d     = part_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;

    shifted = {part_q, dvd_q[n-1]};
    trial   = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (arg_vld) begin
          neg_quot_d = signed_div & (a[n-1] ^ b[n-1]);
          neg_rem_d  = signed_div & a[n-1];
          dvd_d      = (signed_div && a[n-1]) ? -a : a;
          dvs_d      = (signed_div && b[n-1]) ? -b : b;
          part_d     = '0;
          cnt_d      = CW'(n - 1);
          if (b == '0) begin
            quot_d  = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A borrow out of the trial subtract means the divisor did not fit: keep the shifted value.
        if (!trial[n]) begin
          part_d = trial[n-1:0];
          dvd_d  = {dvd_q[n-2:0], 1'b1};
        end else begin
          part_d = shifted[n-1:0];
          dvd_d  = {dvd_q[n-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quot_d  = neg_quot_q ? -dvd_q : dvd_q;
        rem_d   = neg_rem_q ? -part_q : part_q;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      part_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      part_q     <= part_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign arg_rdy     = (state_q == IDLE);
  assign res_vld     = (state_q == DONE);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Self-checking bench for signed_or_unsigned_div (n=8): directed scenarios plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_signed_or_unsigned_div;

  localparam int N       = 8;
  localparam int TIMEOUT = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         arg_vld;
  logic         arg_rdy;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         signed_div;
  logic         res_vld;
  logic         res_rdy;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         div_by_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  signed_or_unsigned_div #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .arg_vld     (arg_vld),
    .arg_rdy     (arg_rdy),
    .a           (a),
    .b           (b),
    .signed_div  (signed_div),
    .res_vld     (res_vld),
    .res_rdy     (res_rdy),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer / and %, with the divide-by-zero convention layered on top.
  function automatic logic [2*N:0] ref_div(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic s);
    int q;
    int r;
    if (y == '0) return {{N{1'b1}}, x, 1'b1};
    if (s) begin
      q = int'($signed(x)) / int'($signed(y));
      r = int'($signed(x)) % int'($signed(y));
    end else begin
      q = int'(x) / int'(y);
      r = int'(x) % int'(y);
    end
    return {q[N-1:0], r[N-1:0], 1'b0};
  endfunction

  // Presents one operand set at a negedge, waits for res_vld and returns the result sampled at
  // the negedge where res_vld is first seen. lat counts negedges after the accepting edge.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic is,
                        input bit take, output logic [2*N:0] res, output int lat);
    a = ia; b = ib; signed_div = is; arg_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
    a = N'($urandom); b = N'($urandom); signed_div = 1'($urandom);
    lat = 0;
    while (!res_vld && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= TIMEOUT) begin
      total_cnt++;
      $display("FAIL timeout: res_vld never rose for a=%h b=%h s=%0b", ia, ib, is);
    end
    res = {quot, rem, div_by_zero};
    if (take) begin
      res_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_rdy = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0; a = '0; b = '0; signed_div = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({arg_rdy, res_vld} !== 2'b10) $display("FAIL reset_handshake: arg_rdy,res_vld=%b want 10", {arg_rdy, res_vld});
    else pass_cnt++;
    total_cnt++;
    if ({quot, rem, div_by_zero} !== '0) $display("FAIL reset_outputs: quot=%h rem=%h dbz=%b want 0", quot, rem, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_unsigned;
    logic [2*N:0] r;
    int lat;
    run_op(8'd200, 8'd7, 1'b0, 1'b1, r, lat);
    total_cnt++;
    if (r !== {8'd28, 8'd4, 1'b0}) $display("FAIL unsigned_200_7: got %h want %h", r, {8'd28, 8'd4, 1'b0});
    else pass_cnt++;
    total_cnt++;
    if (lat !== N + 1) $display("FAIL unsigned_latency: got %0d want %0d", lat, N + 1);
    else pass_cnt++;
  endtask

  task automatic test_signed_modes;
    logic [2*N:0] r;
    int lat;
    run_op(8'hF9, 8'h02, 1'b1, 1'b1, r, lat);
    total_cnt++;
    if (r !== {8'hFD, 8'hFF, 1'b0}) $display("FAIL signed_F9_02: got %h want %h", r, {8'hFD, 8'hFF, 1'b0});
    else pass_cnt++;
    run_op(8'hF9, 8'h02, 1'b0, 1'b1, r, lat);
    total_cnt++;
    if (r !== {8'h7C, 8'h01, 1'b0}) $display("FAIL unsigned_F9_02: got %h want %h", r, {8'h7C, 8'h01, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_div_zero;
    logic [2*N:0] r;
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(8'h55, 8'h00, 1'(s), 1'b1, r, lat);
      total_cnt++;
      if (r !== {8'hFF, 8'h55, 1'b1}) $display("FAIL div_zero_s%0d: got %h want %h", s, r, {8'hFF, 8'h55, 1'b1});
      else pass_cnt++;
      // The zero-divisor path goes straight to DONE on the accepting edge.
      total_cnt++;
      if (lat !== 0) $display("FAIL div_zero_latency_s%0d: got %0d want 0", s, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow;
    logic [2*N:0] r;
    int lat;
    run_op(8'h80, 8'hFF, 1'b1, 1'b1, r, lat);
    total_cnt++;
    if (r !== {8'h80, 8'h00, 1'b0}) $display("FAIL signed_overflow: got %h want %h", r, {8'h80, 8'h00, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [2*N:0] r;
    logic [2*N:0] held;
    int lat;
    run_op(8'd100, 8'd9, 1'b0, 1'b0, r, lat);
    held = ref_div(8'd100, 8'd9, 1'b0);
    a = 8'd50; b = 8'd5; signed_div = 1'b0; arg_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({quot, rem, div_by_zero} !== held || res_vld !== 1'b1 || arg_rdy !== 1'b0)
        $display("FAIL backpressure_hold_%0d: out=%h vld=%b rdy=%b want out=%h vld=1 rdy=0",
                 i, {quot, rem, div_by_zero}, res_vld, arg_rdy, held);
      else pass_cnt++;
      @(negedge clk);
    end
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    total_cnt++;
    if ({arg_rdy, res_vld} !== 2'b10 || {quot, rem, div_by_zero} !== held)
      $display("FAIL backpressure_release: rdy,vld=%b out=%h want 10 out=%h",
               {arg_rdy, res_vld}, {quot, rem, div_by_zero}, held);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [2*N:0] r;
    int lat;
    a = 8'd250; b = 8'd3; signed_div = 1'b0; arg_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({arg_rdy, res_vld, quot, rem} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL reset_mid: rdy=%b vld=%b quot=%h rem=%h want 1 0 00 00", arg_rdy, res_vld, quot, rem);
    else pass_cnt++;
    lat = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (res_vld) lat++;
    end
    total_cnt++;
    if (lat !== 0) $display("FAIL reset_mid_no_result: res_vld seen %0d cycles want 0", lat);
    else pass_cnt++;
    run_op(8'd9, 8'd3, 1'b0, 1'b1, r, lat);
    total_cnt++;
    if (r !== {8'd3, 8'd0, 1'b0}) $display("FAIL after_reset_9_3: got %h want %h", r, {8'd3, 8'd0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [2*N:0] r;
    int lat;
    logic [N-1:0] xa;
    logic [N-1:0] xb;
    res_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xa = N'($urandom); xb = N'($urandom_range(1, 255)); 
      run_op(xa, xb, 1'(i), 1'b0, r, lat);
      @(negedge clk);
      total_cnt++;
      if (r !== ref_div(xa, xb, 1'(i)) || arg_rdy !== 1'b1)
        $display("FAIL back_to_back_%0d: got %h rdy=%b want %h rdy=1", i, r, arg_rdy, ref_div(xa, xb, 1'(i)));
      else pass_cnt++;
    end
    res_rdy = 1'b0;
  endtask

  task automatic test_random;
    logic [2*N:0] r;
    int lat;
    logic [N-1:0] xa;
    logic [N-1:0] xb;
    logic xs;
    for (int i = 0; i < 60; i++) begin
      xa = N'($urandom);
      case ($urandom_range(0, 5))
        0: xb = 8'h00;
        1: xb = 8'hFF;
        2: xb = 8'h01;
        default: xb = N'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) xa = 8'h80;
      xs = 1'($urandom);
      run_op(xa, xb, xs, 1'b1, r, lat);
      total_cnt++;
      if (r !== ref_div(xa, xb, xs) || lat !== ((xb == '0) ? 0 : N + 1))
        $display("FAIL random_%0d a=%h b=%h s=%b: got %h lat=%0d want %h lat=%0d",
                 i, xa, xb, xs, r, lat, ref_div(xa, xb, xs), (xb == '0) ? 0 : N + 1);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed_modes;
    test_div_zero;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
